mlp_result_collector: RTL
=========================

# mlp_result_collector

Consumer end of the MLP output stream. Accepts the signed Q8.8 output-neuron values the network emits, one per handshake, into a small frame buffer. Tracks the running argmax and presents a classification result with a `result_valid`/`result_ack` handshake. Sits directly downstream of `top`'s output and `finished` signals.

## Interface
Parameters:
- `DATA_W`, 16, output word width (signed Q8.8)
- `NUM_OUT`, 10, output neurons per frame
- `IDX_W`, 4, index width; must satisfy `2**IDX_W >= NUM_OUT`

Ports:
- `clk`, input, 1, single clock; all logic is rising-edge
- `reset`, input, 1, synchronous, active-low; sampled on `clk`
- `in_valid`, input, 1, `in_data` holds a valid output word
- `in_data`, input, DATA_W, signed output value
- `in_ready`, output, 1, the collector can accept a word this cycle
- `finished`, input, 1, end-of-frame pulse from the MLP
- `result_valid`, output, 1, a frame is complete and the result is stable
- `result_ack`, input, 1, the consumer has taken the result
- `class_idx`, output, IDX_W, index of the maximum value
- `class_val`, output, DATA_W, maximum value
- `count`, output, IDX_W+1, number of words accepted in the current frame
- `short_frame`, output, 1, the frame ended with fewer than `NUM_OUT` words
- `rd_addr`, input, IDX_W, buffer read address
- `rd_data`, output, DATA_W, buffer word; registered

## Operation
- The FSM has three states: IDLE, COLLECT and DONE.
- `in_ready` is 1 in IDLE and COLLECT and 0 in DONE. It is decoded combinationally from the state register.
- Accept condition: `in_valid & in_ready`. On accept:
  - `buf[count] <= in_data`
  - `count` increments
  - the argmax is updated
- IDLE -> COLLECT on the first accept.
- COLLECT -> DONE on an accept that brings `count` to `NUM_OUT`.
- COLLECT -> DONE when `finished` is asserted. `short_frame` is set if `count` is less than `NUM_OUT` after any same-cycle accept.
- `finished` in IDLE with no accept is ignored.
- DONE -> IDLE on `result_ack`. The IDLE entry clears `count`, `short_frame` and the argmax registers. Buffer contents are retained.
- Argmax update rule:
  - The first word of the frame loads unconditionally.
  - After that, the registers update only if `in_data` is strictly greater than `class_val`, compared as signed values.
  - On a tie the lower index is kept.
  - -32768 is a legal value.
- `in_valid` in DONE is not accepted. The producer must hold the word until `in_ready` returns.
- Any number of extra `finished` pulses in DONE are ignored.

## Timing
- Every output is 0 while `reset` is 0 and on the first cycle after it is released. The state is IDLE.
- Accepted data is visible on `count`, `class_idx` and `class_val` one cycle after the accepting edge.
- `result_valid` rises one cycle after the terminating accept or `finished`. It stays high until the cycle after `result_ack`.
- `result_ack` while `result_valid` is 0 is ignored.
- `in_ready` returns to 1 one cycle after `result_ack` is sampled. There is no same-cycle bypass.
- `rd_data` is `buf[rd_addr]` one cycle later. It can be read in any state.
- Reset asserted mid-frame returns to IDLE within one edge and discards the partial frame.

## Configuration
- `MLP_COLLECT_ARGMAX_EN` defined:
  - the argmax tracker is instantiated
  - `class_idx` and `class_val` behave as specified above
- `MLP_COLLECT_ARGMAX_EN` undefined:
  - the tracker is not built
  - `class_idx` and `class_val` are tied to 0
  - the buffer, `count`, `short_frame` and the handshake are unchanged

## Structure
- Shared package `mlp_pkg` holds:
  - the `DATA_W` default
  - the state encoding constants IDLE=0, COLLECT=1, DONE=2
- One sub-module, `argmax_tracker`. Its inputs are `clk`, `reset`, `clear`, `load`, `first`, `idx` and `val`. It holds the `class_idx` and `class_val` registers.
- The top level of this block contains the FSM, the buffer array and the read port.

## Test plan
- Reset, then stream 10 words 1..10 with `in_valid` held high -> accepts on 10 consecutive cycles, `result_valid`=1, `class_idx`=9, `class_val`=10, `count`=10, `short_frame`=0.
- Stream -5, 3, 3, -32768, 0, ... (10 words) -> `class_idx`=1 (tie keeps the lower index), `class_val`=3.
- Stream 4 words, then pulse `finished` -> DONE with `count`=4 and `short_frame`=1. Read `rd_addr`=3 -> the 4th word one cycle later.
- In DONE, hold `in_valid`=1 with value 0x7FFF -> `in_ready`=0 and no change. Pulse `result_ack` -> IDLE next cycle, and 0x7FFF is then accepted as word 0 of the new frame.
- Pull `reset` low after 6 of 10 words -> all outputs 0 next cycle. A full new frame then produces the correct argmax.
- Build without `MLP_COLLECT_ARGMAX_EN` -> `class_idx`=0 and `class_val`=0 throughout, and the handshake and buffer results match the first scenario.

Source files
------------

// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP output-side blocks: word width default and
// the result-collector state encoding.
package mlp_pkg;

    localparam int MLP_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/argmax_tracker.sv
// Running argmax over one frame of signed words; the first word loads
// unconditionally, later words replace only when strictly greater.
module argmax_tracker #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic              first,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] val,
    output logic [IDX_W-1:0]  class_idx,
    output logic [DATA_W-1:0] class_val
);

    // strict compare keeps the lower index on ties
    logic take;
    assign take = load && (first || ($signed(val) > $signed(class_val)));

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            class_idx <= '0;
            class_val <= '0;
        end else if (take) begin
            class_idx <= idx;
            class_val <= val;
        end
    end

endmodule

// File: rtl/mlp_result_collector.sv
// Frame buffer + classification result handshake for the MLP output stream.
// Define MLP_COLLECT_ARGMAX_EN to build the argmax tracker; otherwise class_* read 0.
module mlp_result_collector
    import mlp_pkg::*;
#(
    parameter int DATA_W  = MLP_DATA_W,
    parameter int NUM_OUT = 10,
    parameter int IDX_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              finished,
    output logic              result_valid,
    input  logic              result_ack,
    output logic [IDX_W-1:0]  class_idx,
    output logic [DATA_W-1:0] class_val,
    output logic [IDX_W:0]    count,
    output logic              short_frame,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int          BUF_D = 1 << IDX_W;
    localparam logic [IDX_W:0] FULL = (IDX_W+1)'(NUM_OUT);

    state_t         state, state_nxt;
    logic           rst_done;
    logic [IDX_W:0] count_nxt, cnt_inc;
    logic           short_nxt;
    logic           accept;
    logic [DATA_W-1:0] mem [BUF_D];

    // rst_done holds every output at 0 for the first cycle after release
    assign in_ready     = reset && rst_done && (state != DONE);
    assign accept       = in_valid && in_ready;
    assign result_valid = (state == DONE);
    assign cnt_inc      = count + 1'b1;

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        short_nxt = short_frame;
        case (state)
            IDLE, COLLECT: begin
                if (accept)
                    count_nxt = cnt_inc;
                if (accept && (cnt_inc == FULL)) begin
                    state_nxt = DONE;
                end else if (finished && ((state == COLLECT) || accept)) begin
                    state_nxt = DONE;
                    short_nxt = (count_nxt < FULL);
                end else if (accept) begin
                    state_nxt = COLLECT;
                end
            end
            DONE: begin
                if (result_ack) begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                    short_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            rst_done    <= 1'b0;
            count       <= '0;
            short_frame <= 1'b0;
        end else begin
            state       <= state_nxt;
            rst_done    <= 1'b1;
            count       <= count_nxt;
            short_frame <= short_nxt;
        end
    end

    // buffer is deliberately not reset so a result can still be read back
    always_ff @(posedge clk) begin
        if (accept)
            mem[count[IDX_W-1:0]] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            rd_data <= '0;
        else
            rd_data <= mem[rd_addr];
    end

`ifdef MLP_COLLECT_ARGMAX_EN
    logic trk_clear;
    assign trk_clear = (state == DONE) && result_ack;

    argmax_tracker #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_argmax (
        .clk       (clk),
        .reset     (reset),
        .clear     (trk_clear),
        .load      (accept),
        .first     (count == '0),
        .idx       (count[IDX_W-1:0]),
        .val       (in_data),
        .class_idx (class_idx),
        .class_val (class_val)
    );
`else
    assign class_idx = '0;
    assign class_val = '0;
`endif

endmodule
